// File: rtl/toggle_pulse_gen.sv
// Debounced button / periodic / burst toggle-request generator
// for a downstream T flip-flop, with a running pulse counter.
module toggle_pulse_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             start,
  output logic             t,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [2:0] {
    OFF,
    MANUAL,
    PERIODIC,
    BURST_IDLE,
    BURST_RUN
  } state_t;

  localparam logic [7:0]       DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic             btn_db;
  logic             db_q;
  logic [7:0]       deb_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rem;
  logic [1:0]       mode_q;
  state_t           st;
  state_t           st_mode;
  logic             hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      btn_db  <= 1'b0;
      db_q    <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= btn_db;
      // s2 is 1 bit: any change while differing brings it back to btn_db
      if (s2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_db  <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    st_mode = OFF;
    unique case (1'b1)
      mode == 2'b01: st_mode = MANUAL;
      mode == 2'b10: st_mode = PERIODIC;
      mode == 2'b11: st_mode = BURST_IDLE;
      default:       st_mode = OFF;
    endcase
  end

  // >= so a period lowered below the running count fires at the next compare
  assign hit = (cnt >= period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= OFF;
      mode_q    <= 2'b00;
      cnt       <= '0;
      rem       <= '0;
      t         <= 1'b0;
      busy      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      mode_q <= mode;
      t      <= 1'b0;
      if (mode != mode_q) begin
        st   <= st_mode;
        cnt  <= '0;
        rem  <= '0;
        busy <= 1'b0;
      end else begin
        unique case (st)
          MANUAL: begin
            if (btn_db && !db_q) begin
              t         <= 1'b1;
              pulse_cnt <= pulse_cnt + ONE;
            end
          end
          PERIODIC: begin
            if (hit) begin
              t         <= 1'b1;
              pulse_cnt <= pulse_cnt + ONE;
              cnt       <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          BURST_IDLE: begin
            if (start && burst_len != '0) begin
              rem  <= burst_len;
              cnt  <= '0;
              st   <= BURST_RUN;
              busy <= 1'b1;
            end
          end
          BURST_RUN: begin
            if (hit) begin
              t         <= 1'b1;
              pulse_cnt <= pulse_cnt + ONE;
              cnt       <= '0;
              rem       <= rem - ONE;
              if (rem == ONE) begin
                st   <= BURST_IDLE;
                busy <= 1'b0;
              end
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
